// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state codes,
// word geometry and the default header word-count limit.
package imem_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_HDR   = 3'd1;
    localparam state_t S_DATA  = 3'd2;
    localparam state_t S_WRITE = 3'd3;
    localparam state_t S_CHK   = 3'd4;
    localparam state_t S_DONE  = 3'd5;
    localparam state_t S_ERR   = 3'd6;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_MAX_WORDS  = 256;

    // A header is usable only when it announces at least one word and no more than the limit.
    function automatic logic count_ok(input logic [31:0] n, input logic [31:0] max_words);
        return (n != 32'd0) && (n <= max_words);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader control, byte-stream and instruction-memory write signals bundled
// into one interface; the loader sits on the slave side.
interface imem_loader_if;

    logic        Start;
    logic [31:0] BaseAddr;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic [31:0] IMemAddr;
    logic [31:0] IMemWrData;
    logic        IMemWrEn;
    logic        ProcReset_L;
    logic        Busy;
    logic        Done;
    logic        Error;

    modport master (
        output Start, BaseAddr, RxData, RxValid,
        input  RxReady, IMemAddr, IMemWrData, IMemWrEn, ProcReset_L, Busy, Done, Error
    );

    modport slave (
        input  Start, BaseAddr, RxData, RxValid,
        output RxReady, IMemAddr, IMemWrData, IMemWrEn, ProcReset_L, Busy, Done, Error
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: gathers accepted bytes MSB-first into a 32-bit word and flags
// the accept that completes it; the completing byte is merged combinationally.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_complete
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // Shift register and byte position; position survives stall cycles untouched.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_shift <= 24'd0;
            r_cnt   <= 2'd0;
        end else if (i_clear) begin
            r_shift <= 24'd0;
            r_cnt   <= 2'd0;
        end else if (i_accept) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end else begin
            r_shift <= r_shift;
            r_cnt   <= r_cnt;
        end
    end

    assign o_word          = {r_shift, i_byte};
    assign o_word_complete = i_accept && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a big-endian word count and instruction words over a
// byte channel and writes them to instruction memory, holding the processor in
// reset until a load succeeds. Define IMEM_LOADER_CHECKSUM_EN to require a
// trailing 32-bit checksum of the data words.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic         CLK,
    input  logic         Reset_L,
    imem_loader_if.slave bus
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_base;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] r_count;
    logic             r_rx_ready;
    logic             r_wr_en;
    logic [31:0]      r_addr;
    logic [31:0]      r_wr_data;
    logic             r_proc_rst_n;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]      r_sum;
`endif

    logic        w_start_ok;
    logic        w_accept;
    logic [31:0] w_word;
    logic        w_word_complete;
    logic        w_last;

    assign w_start_ok = bus.Start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_accept   = bus.RxValid && r_rx_ready;
    assign w_last     = ((r_index + IDX_W'(1)) == r_count);

    byte_packer u_packer (
        .CLK             (CLK),
        .Reset_L         (Reset_L),
        .i_clear         (w_start_ok),
        .i_accept        (w_accept),
        .i_byte          (bus.RxData),
        .o_word          (w_word),
        .o_word_complete (w_word_complete)
    );

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_start_ok) w_next_state = S_HDR;
                else            w_next_state = r_state;
            end
            S_HDR: begin
                if (w_word_complete) w_next_state = count_ok(w_word, 32'(MAX_WORDS)) ? S_DATA : S_ERR;
                else                 w_next_state = S_HDR;
            end
            S_DATA: begin
                if (w_word_complete) w_next_state = S_WRITE;
                else                 w_next_state = S_DATA;
            end
            S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (w_last) w_next_state = S_CHK;
`else
                if (w_last) w_next_state = S_DONE;
`endif
                else        w_next_state = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_word_complete) w_next_state = (w_word == r_sum) ? S_DONE : S_ERR;
                else                 w_next_state = S_CHK;
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    // State and status outputs, registered from the next state so they line up with it.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state      <= S_IDLE;
            r_rx_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_proc_rst_n <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_rx_ready   <= (w_next_state == S_HDR) || (w_next_state == S_DATA) || (w_next_state == S_CHK);
            r_wr_en      <= (w_next_state == S_WRITE);
            r_busy       <= (w_next_state == S_HDR) || (w_next_state == S_DATA) ||
                            (w_next_state == S_WRITE) || (w_next_state == S_CHK);
            r_done       <= (w_next_state == S_DONE);
            r_error      <= (w_next_state == S_ERR);
            r_proc_rst_n <= (w_next_state == S_DONE);
        end
    end

    // Load context and write port; address and data hold between write strobes.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_base    <= 32'd0;
            r_index   <= '0;
            r_count   <= '0;
            r_addr    <= 32'd0;
            r_wr_data <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum     <= 32'd0;
`endif
        end else if (w_start_ok) begin
            r_base  <= bus.BaseAddr & 32'hFFFF_FFFC;
            r_index <= '0;
            r_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum   <= 32'd0;
`endif
        end else if ((r_state == S_HDR) && w_word_complete) begin
            r_count <= w_word[IDX_W-1:0];
        end else if ((r_state == S_DATA) && w_word_complete) begin
            r_addr    <= r_base + (32'(r_index) << 2);
            r_wr_data <= w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum     <= r_sum + w_word;
`endif
        end else if (r_state == S_WRITE) begin
            r_index <= r_index + IDX_W'(1);
        end
    end

    assign bus.RxReady     = r_rx_ready;
    assign bus.IMemAddr    = r_addr;
    assign bus.IMemWrData  = r_wr_data;
    assign bus.IMemWrEn    = r_wr_en;
    assign bus.ProcReset_L = r_proc_rst_n;
    assign bus.Busy        = r_busy;
    assign bus.Done        = r_done;
    assign bus.Error       = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of directed loads, hand-written
// timing/reset sequences, and random loads checked against a list-based model.
module tb_imem_loader;

    localparam int TB_MAX = 256;

    logic CLK;
    logic Reset_L;
    imem_loader_if bus();

    imem_loader #(.MAX_WORDS(TB_MAX)) dut (.CLK(CLK), .Reset_L(Reset_L), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];

    typedef struct {
        logic [31:0] base;
        logic [31:0] n;
        logic [31:0] w [4];
        int          idle;
        bit          poke;
        bit          exp_done;
    } vec_t;

    vec_t vecs [8];

    always @(negedge CLK) begin
        if (bus.IMemWrEn === 1'b1) begin
            got_a.push_back(bus.IMemAddr);
            got_d.push_back(bus.IMemWrData);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] base, input logic [31:0] n,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input int idle, input bit poke, input bit done);
        vec_t v;
        v.base = base; v.n = n;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.idle = idle; v.poke = poke; v.exp_done = done;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        int t;
        for (int k = 0; k < idle; k++) begin
            bus.RxValid = 1'b0;
            tick();
        end
        bus.RxData  = b;
        bus.RxValid = 1'b1;
        t = 0;
        while (bus.RxReady !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        chk("rxready_timeout", (t >= 50) ? 32'd1 : 32'd0, 32'd0);
        tick();
        bus.RxValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int idle, input bit rnd);
        for (int k = 3; k >= 0; k--)
            send_byte(w[k*8 +: 8], rnd ? int'($urandom_range(0, 2)) : idle);
    endtask

    // Start with a byte offered at the same time: that byte must not be taken.
    task automatic do_start(input logic [31:0] base);
        bus.Start    = 1'b1;
        bus.BaseAddr = base;
        bus.RxValid  = 1'b1;
        bus.RxData   = 8'hFF;
        chk("start_rxready", {31'd0, bus.RxReady}, 32'd0);
        tick();
        bus.Start   = 1'b0;
        bus.RxValid = 1'b0;
        chk("start_busy",    {31'd0, bus.Busy},        32'd1);
        chk("start_done",    {31'd0, bus.Done},        32'd0);
        chk("start_error",   {31'd0, bus.Error},       32'd0);
        chk("start_procrst", {31'd0, bus.ProcReset_L}, 32'd0);
    endtask

    task automatic run_load(input logic [31:0] base, input logic [31:0] n,
                            input logic [31:0] words[$], input int idle, input bit rnd,
                            input bit poke, input bit bad_sum, input bit exp_done);
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        logic [31:0] sum;
        bit          ok;
        int          t;
        ok  = (n != 32'd0) && (n <= 32'(TB_MAX));
        sum = 32'd0;
        if (ok) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_a.push_back((base & 32'hFFFF_FFFC) + 32'(4 * i));
                exp_d.push_back(words[i]);
                sum = sum + words[i];
            end
        end
        got_a.delete();
        got_d.delete();
        do_start(base);
        send_word(n, idle, rnd);
        if (poke) begin
            bus.Start    = 1'b1;
            bus.BaseAddr = 32'hDEAD_0000;
            tick();
            bus.Start = 1'b0;
        end
        if (ok) begin
            for (int i = 0; i < int'(n); i++) send_word(words[i], idle, rnd);
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_word(bad_sum ? sum + 32'd1 : sum, idle, rnd);
`endif
        end
        t = 0;
        while (bus.Busy === 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk("busy_timeout",  (t >= 20) ? 32'd1 : 32'd0, 32'd0);
        chk("end_done",      {31'd0, bus.Done},        {31'd0, exp_done});
        chk("end_error",     {31'd0, bus.Error},       {31'd0, !exp_done});
        chk("end_procrst",   {31'd0, bus.ProcReset_L}, {31'd0, exp_done});
        chk("write_count",   32'(got_a.size()),        32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            chk("write_addr", got_a[i], exp_a[i]);
            chk("write_data", got_d[i], exp_d[i]);
        end
        if (exp_a.size() > 0) begin
            chk("hold_addr", bus.IMemAddr,   exp_a[exp_a.size()-1]);
            chk("hold_data", bus.IMemWrData, exp_d[exp_d.size()-1]);
        end
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] n;

        vecs[0] = mk(32'h0000_0040, 32'd2, 32'h8C01_0000, 32'hAC01_0004, 32'h0, 32'h0, 0, 1'b0, 1'b1);
        vecs[1] = mk(32'h0000_0000, 32'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        vecs[2] = mk(32'h0000_0000, 32'd257, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        vecs[3] = mk(32'h0000_1000, 32'd1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1, 1'b0, 1'b1);
        vecs[4] = mk(32'h0000_0103, 32'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0, 0, 1'b1, 1'b1);
        vecs[5] = mk(32'hFFFF_FFFC, 32'd2, 32'hCAFE_F00D, 32'h1234_5678, 32'h0, 32'h0, 0, 1'b0, 1'b1);
        vecs[6] = mk(32'h0000_0000, 32'h0100_0001, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        vecs[7] = mk(32'h0000_0020, 32'd4, 32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003, 32'hF0F0_0004, 1, 1'b0, 1'b1);

        Reset_L      = 1'b0;
        bus.Start    = 1'b0;
        bus.BaseAddr = 32'd0;
        bus.RxData   = 8'd0;
        bus.RxValid  = 1'b0;
        #12;
        chk("rst_rxready", {31'd0, bus.RxReady},     32'd0);
        chk("rst_wren",    {31'd0, bus.IMemWrEn},    32'd0);
        chk("rst_busy",    {31'd0, bus.Busy},        32'd0);
        chk("rst_done",    {31'd0, bus.Done},        32'd0);
        chk("rst_error",   {31'd0, bus.Error},       32'd0);
        chk("rst_procrst", {31'd0, bus.ProcReset_L}, 32'd0);
        chk("rst_addr",    bus.IMemAddr,             32'd0);
        chk("rst_data",    bus.IMemWrData,           32'd0);
        Reset_L = 1'b1;
        tick();

        // Write latency and Done timing on the reference two-word load.
        do_start(32'h0000_0040);
        send_word(32'd2, 0, 1'b0);
        send_word(32'h8C01_0000, 0, 1'b0);
        chk("lat_wren0", {31'd0, bus.IMemWrEn}, 32'd1);
        chk("lat_addr0", bus.IMemAddr,          32'h0000_0040);
        chk("lat_data0", bus.IMemWrData,        32'h8C01_0000);
        send_word(32'hAC01_0004, 0, 1'b0);
        chk("lat_wren1", {31'd0, bus.IMemWrEn}, 32'd1);
        chk("lat_addr1", bus.IMemAddr,          32'h0000_0044);
        chk("lat_data1", bus.IMemWrData,        32'hAC01_0004);
`ifndef IMEM_LOADER_CHECKSUM_EN
        tick();
        chk("lat_wren_off", {31'd0, bus.IMemWrEn},    32'd0);
        chk("lat_done",     {31'd0, bus.Done},        32'd1);
        chk("lat_procrst",  {31'd0, bus.ProcReset_L}, 32'd1);
        chk("lat_busy",     {31'd0, bus.Busy},        32'd0);
`else
        send_word(32'h3802_0004, 0, 1'b0);
        chk("lat_done_chk", {31'd0, bus.Done}, 32'd1);
`endif

        for (int v = 0; v < 8; v++) begin
            q.delete();
            for (int k = 0; k < 4 && k < int'(vecs[v].n); k++) q.push_back(vecs[v].w[k]);
            run_load(vecs[v].base, vecs[v].n, q, vecs[v].idle, 1'b0, vecs[v].poke, 1'b0, vecs[v].exp_done);
        end

        // Largest accepted count.
        q.delete();
        for (int k = 0; k < TB_MAX; k++) q.push_back($urandom);
        run_load(32'h0001_0000, 32'(TB_MAX), q, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a data word abandons the load.
        got_a.delete();
        do_start(32'h0000_0080);
        send_word(32'd1, 0, 1'b0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        Reset_L = 1'b0;
        #2;
        chk("mid_rst_rxready", {31'd0, bus.RxReady},     32'd0);
        chk("mid_rst_wren",    {31'd0, bus.IMemWrEn},    32'd0);
        chk("mid_rst_busy",    {31'd0, bus.Busy},        32'd0);
        chk("mid_rst_done",    {31'd0, bus.Done},        32'd0);
        chk("mid_rst_error",   {31'd0, bus.Error},       32'd0);
        chk("mid_rst_procrst", {31'd0, bus.ProcReset_L}, 32'd0);
        chk("mid_rst_addr",    bus.IMemAddr,             32'd0);
        chk("mid_rst_data",    bus.IMemWrData,           32'd0);
        tick();
        Reset_L = 1'b1;
        tick();
        tick();
        chk("mid_rst_nowrite", 32'(got_a.size()), 32'd0);
        q.delete();
        q.push_back(32'h1234_5678);
        run_load(32'h0000_0080, 32'd1, q, 0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        q.delete();
        q.push_back(32'h0000_0001);
        q.push_back(32'h0000_0002);
        run_load(32'h0, 32'd2, q, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_load(32'h0, 32'd2, q, 0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // Random loads against the list model.
        for (int r = 0; r < 20; r++) begin
            bit bad;
            case ($urandom_range(0, 7))
                0:       n = 32'd0;
                1:       n = 32'(TB_MAX + 1) + ($urandom & 32'h0000_00FF);
                2:       n = $urandom | 32'h8000_0000;
                default: n = 32'($urandom_range(1, 5));
            endcase
            q.delete();
            if (n <= 32'd5) for (int k = 0; k < int'(n); k++) q.push_back($urandom);
            bad = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            bad = ($urandom_range(0, 3) == 0);
`endif
            run_load($urandom, n, q, 0, 1'b1, 1'b0, bad,
                     (n != 32'd0) && (n <= 32'(TB_MAX)) && !bad);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have one parameter: MAX_WORDS, default 256, the largest word count accepted in a header.
REQ-002 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Reset_L  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  one-cycle pulse that begins a load; ignored while Busy=1.
REQ-005 BaseAddr  input  32  byte address of the first instruction word; sampled on an accepted Start; bits [1:0] forced to 0.
REQ-006 RxData  input  8  incoming byte stream.
REQ-007 RxValid  input  1  RxData holds a valid byte.
REQ-008 RxReady  output  1  the loader accepts a byte; a byte transfers on a rising edge when RxValid and RxReady are both 1.
REQ-009 IMemAddr  output  32  instruction-memory write byte address.
REQ-010 IMemWrData  output  32  instruction word to write.
REQ-011 IMemWrEn  output  1  one-cycle write strobe to the instruction memory.
REQ-012 ProcReset_L  output  1  active-low reset to the processor; 0 holds it, 1 releases it.
REQ-013 Busy  output  1  a load is in progress.
REQ-014 Done  output  1  the last load completed successfully.
REQ-015 Error  output  1  the last load was rejected.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, HDR, DATA, WRITE, CHK, DONE, ERR.
REQ-017 In IDLE, DONE and ERR, an accepted Start SHALL capture BaseAddr, clear the word index and the byte counter, clear Done and Error, drive ProcReset_L=0, and move to HDR.
REQ-018 In HDR, RxReady SHALL be 1; four accepted bytes form the big-endian word count N, with the first byte as bits [31:24].
REQ-019 After the 4th header byte, N=0 or N>MAX_WORDS SHALL go to ERR; otherwise the FSM SHALL go to DATA.
REQ-020 In DATA, RxReady SHALL be 1; four accepted bytes form one big-endian word, and the 4th byte SHALL move the FSM to WRITE.
REQ-021 In WRITE, RxReady SHALL be 0 and IMemWrEn SHALL be 1 for exactly one cycle, with IMemAddr = base + 4*index (modulo 2^32) and IMemWrData = the assembled word.
REQ-022 The write SHALL occur in the cycle after the 4th byte of the word is accepted (latency 1).
REQ-023 After each write the index SHALL increment; if index = N the FSM SHALL go to CHK (with the macro) or DONE (without it), otherwise back to DATA.
REQ-024 Cycles with RxValid=0 SHALL stall the FSM without loss of state; byte-counter position SHALL be preserved.
REQ-025 Busy SHALL be 1 in HDR, DATA, WRITE and CHK only.
REQ-026 In DONE, Done=1 and ProcReset_L=1 SHALL hold until the next accepted Start.
REQ-027 In ERR, Error=1 and ProcReset_L=0 SHALL hold until the next accepted Start.
REQ-028 IMemAddr and IMemWrData SHALL hold their last values when IMemWrEn=0.
REQ-029 Start asserted together with RxValid SHALL take priority, and that byte SHALL not be consumed (RxReady=0 in the Start cycle).

Reset
REQ-030 Reset_L=0 SHALL immediately force state IDLE, with RxReady, IMemWrEn, Busy, Done, Error and ProcReset_L all 0, and IMemAddr, IMemWrData and all counters at 0.
REQ-031 Reset mid-load SHALL abandon the load with no further IMemWrEn pulses; words already written SHALL remain in memory.

Configuration
REQ-032 With macro IMEM_LOADER_CHECKSUM_EN defined, CHK SHALL accept four more big-endian bytes and compare them with the 32-bit modulo sum of all N data words: equal goes to DONE, unequal goes to ERR.
REQ-033 Without IMEM_LOADER_CHECKSUM_EN, CHK SHALL be unreachable, no checksum logic SHALL exist, and the FSM SHALL go from the last WRITE directly to DONE.

Structure
REQ-034 Package imem_loader_pkg SHALL hold the state enumeration, BYTES_PER_WORD=4, and the default MAX_WORDS.
REQ-035 One sub-module, byte_packer, SHALL shift accepted bytes into a 32-bit word with a 2-bit counter and flag word_complete.

Verification
REQ-036 Header 00000002 with words 8C010000, AC010004, BaseAddr=0x40 and continuous RxValid -> writes (0x40,8C010000) then (0x44,AC010004); Done=1 and ProcReset_L=1 one cycle after the last write.
REQ-037 Header 00000000 -> Error=1, ProcReset_L=0, and no IMemWrEn pulse.
REQ-038 Header with N=MAX_WORDS+1 -> ERR; then Start followed by a valid N=1 load -> Error cleared and Done=1.
REQ-039 RxValid toggling every other cycle during an N=1 load -> same single write, delayed but with identical address and data.
REQ-040 Reset_L pulsed low after two of four data bytes -> all outputs 0 immediately; no write; a new Start then works normally.
REQ-041 With IMEM_LOADER_CHECKSUM_EN, words 00000001 and 00000002 followed by checksum 00000003 -> DONE; the same words followed by checksum 00000004 -> ERR.
